// File: rtl/muldiv_pkg.sv
// Shared encodings for the sequential multiply/divide engine.
// mdx operation codes and the controller state type.
package muldiv_pkg;

    localparam logic [1:0] MDX_MUL   = 2'b00;
    localparam logic [1:0] MDX_MULTU = 2'b01;
    localparam logic [1:0] MDX_DIV   = 2'b10;
    localparam logic [1:0] MDX_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_t;

endpackage

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU engine with HI/LO holding registers.
// One shift-add / restoring shift-subtract step per cycle, then a sign fix-up cycle.
//
// state | meaning
// IDLE  | waiting for start; hi/lo hold the last result
// CALC  | one multiply or divide iteration per cycle, WIDTH iterations
// FIX   | sign correction, write hi/lo, pulse done
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       mdx,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam int CW = $clog2(WIDTH) + 1;

    function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] x, input logic is_signed);
        return (is_signed && x[WIDTH-1]) ? -x : x;
    endfunction

    state_t           state_q, state_d;
    logic             div_q, div_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic             div0_q, div0_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH:0]   hacc_q, hacc_d;
    logic [WIDTH-1:0] lacc_q, lacc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    // Shared adder: add (gated multiplicand) for multiply, subtract divisor for divide.
    logic [WIDTH:0]     add_x, add_y;
    logic [WIDTH+1:0]   sum;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic               in_signed, in_div;

    assign add_x = div_q ? {hacc_q[WIDTH-1:0], lacc_q[WIDTH-1]} : hacc_q;
    assign add_y = div_q ? ~{1'b0, opnd_q} : (lacc_q[0] ? {1'b0, opnd_q} : '0);
    assign sum   = {1'b0, add_x} + {1'b0, add_y} + (WIDTH+2)'(div_q);
    assign prod  = {hacc_q[WIDTH-1:0], lacc_q};

    assign in_signed = (mdx == MDX_MUL) || (mdx == MDX_DIV);
    assign in_div    = (mdx == MDX_DIV) || (mdx == MDX_DIVU);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            div_q   <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            div0_q  <= 1'b0;
            opnd_q  <= '0;
            hacc_q  <= '0;
            lacc_q  <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            div0_q  <= div0_d;
            opnd_q  <= opnd_d;
            hacc_q  <= hacc_d;
            lacc_q  <= lacc_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        div0_d  = div0_q;
        opnd_d  = opnd_q;
        hacc_d  = hacc_q;
        lacc_d  = lacc_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        prod_s  = prod;

        case (state_q)
            IDLE: begin
                if (start) begin
                    div_d  = in_div;
                    sa_d   = in_signed & a[WIDTH-1];
                    sb_d   = in_signed & b[WIDTH-1];
                    div0_d = (b == '0);
                    hacc_d = '0;
                    cnt_d  = CW'(WIDTH);
                    // Divide shifts the dividend out of lacc; multiply shifts the multiplier out.
                    if (in_div) begin
                        lacc_d = abs_w(a, in_signed);
                        opnd_d = abs_w(b, in_signed);
                    end else begin
                        lacc_d = abs_w(b, in_signed);
                        opnd_d = abs_w(a, in_signed);
                    end
                    state_d = CALC;
                end
            end
            CALC: begin
                if (div_q) begin
                    if (sum[WIDTH+1]) begin
                        hacc_d = sum[WIDTH:0];
                        lacc_d = {lacc_q[WIDTH-2:0], 1'b1};
                    end else begin
                        hacc_d = add_x;
                        lacc_d = {lacc_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    hacc_d = {1'b0, sum[WIDTH:1]};
                    lacc_d = {sum[0], lacc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (div_q) begin
                    // Divide-by-zero keeps an all-ones quotient regardless of signs.
                    lo_d = (sa_q ^ sb_q) && !div0_q ? -lacc_q : lacc_q;
                    hi_d = sa_q ? -hacc_q[WIDTH-1:0] : hacc_q[WIDTH-1:0];
                end else begin
                    prod_s = (sa_q ^ sb_q) ? -prod : prod;
                    hi_d   = prod_s[2*WIDTH-1:WIDTH];
                    lo_d   = prod_s[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
